// File: rtl/exmem_pkg.sv
// EX->MEM stage shared types and default widths.
// Optional stall counter enabled with EXMEM_STALL_CNT_EN.
package exmem_pkg;

  localparam int EXMEM_ADDR_W  = 16;
  localparam int EXMEM_RADDR_W = 3;
  localparam int EXMEM_DATA_W  = 32;
  localparam int EXMEM_CNT_W   = 16;

  typedef struct packed {
    logic [EXMEM_ADDR_W-1:0]  mem_addr;
    logic [EXMEM_RADDR_W-1:0] rdest_addr;
    logic [EXMEM_DATA_W-1:0]  rdest_data;
    logic                     store;
  } exmem_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } exmem_occ_e;

endpackage

// File: rtl/exmem_entry_reg.sv
// One EX->MEM entry register with load enable and sync reset.
// Entry type is a parameter so the top can resize the payload.
module exmem_entry_reg
  import exmem_pkg::*;
#(
  parameter type T = exmem_entry_t
) (
  input  logic clk,
  input  logic resetn,
  input  logic ld,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX->MEM pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Define EXMEM_STALL_CNT_EN to add the saturating stall_cnt output.
module exmem_pipe_stage
  import exmem_pkg::*;
#(
  parameter int ADDR_W  = EXMEM_ADDR_W,
  parameter int RADDR_W = EXMEM_RADDR_W,
  parameter int DATA_W  = EXMEM_DATA_W
`ifdef EXMEM_STALL_CNT_EN
  ,
  parameter int CNT_W   = EXMEM_CNT_W
`endif
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_mem_addr,
  input  logic [RADDR_W-1:0] in_rdest_addr,
  input  logic [DATA_W-1:0]  in_rdest_data,
  input  logic               in_store,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_mem_addr,
  output logic [RADDR_W-1:0] out_rdest_addr,
  output logic [DATA_W-1:0]  out_rdest_data,
  output logic               out_store
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0]  mem_addr;
    logic [RADDR_W-1:0] rdest_addr;
    logic [DATA_W-1:0]  rdest_data;
    logic               store;
  } entry_t;

  exmem_occ_e state, state_nxt;

  entry_t in_e, main_q, skid_q, main_d;
  logic   main_ld, skid_ld;
  logic   acc, drn;

  assign in_e = '{
    mem_addr:   in_mem_addr,
    rdest_addr: in_rdest_addr,
    rdest_data: in_rdest_data,
    store:      in_store
  };

  assign in_ready  = (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = in_e;
    unique case (state)
      OCC_EMPTY: begin
        if (acc) begin
          main_ld   = 1'b1;
          state_nxt = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && drn) begin
          main_ld = 1'b1;
        end else if (acc) begin
          skid_ld   = 1'b1;
          state_nxt = OCC_FULL;
        end else if (drn) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (drn) begin
          main_ld   = 1'b1;
          main_d    = skid_q;
          state_nxt = OCC_ONE;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
    // Stale payload left in the regs is harmless once occupancy is EMPTY.
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end
  end

  exmem_entry_reg #(.T(entry_t)) u_main (
    .clk    (clk),
    .resetn (resetn),
    .ld     (main_ld),
    .d      (main_d),
    .q      (main_q)
  );

  exmem_entry_reg #(.T(entry_t)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .ld     (skid_ld),
    .d      (in_e),
    .q      (skid_q)
  );

  assign out_mem_addr   = main_q.mem_addr;
  assign out_rdest_addr = main_q.rdest_addr;
  assign out_rdest_data = main_q.rdest_data;
  assign out_store      = main_q.store & out_valid;

`ifdef EXMEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed testbench for exmem_pipe_stage.
// Build with EXMEM_STALL_CNT_EN to also cover the stall counter.
module tb_exmem_pipe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mem_addr;
  logic [2:0]  in_rdest_addr;
  logic [31:0] in_rdest_data;
  logic        in_store;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mem_addr;
  logic [2:0]  out_rdest_addr;
  logic [31:0] out_rdest_data;
  logic        out_store;
`ifdef EXMEM_STALL_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exmem_pipe_stage #(
    .ADDR_W  (16),
    .RADDR_W (3),
    .DATA_W  (32)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .CNT_W   (4)
`endif
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_addr    (in_mem_addr),
    .in_rdest_addr  (in_rdest_addr),
    .in_rdest_data  (in_rdest_data),
    .in_store       (in_store),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mem_addr   (out_mem_addr),
    .out_rdest_addr (out_rdest_addr),
    .out_rdest_data (out_rdest_data),
    .out_store      (out_store)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a,
                       input logic [2:0] r, input logic [31:0] d,
                       input logic s);
    in_valid      = v;
    in_mem_addr   = a;
    in_rdest_addr = r;
    in_rdest_data = d;
    in_store      = s;
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'hbeef, 3'd7, 32'hdeadbeef, 1'b1);

    // reset with in_valid asserted
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_addr", out_mem_addr, 0);
    chk("rst_rdest", out_rdest_addr, 0);
    chk("rst_data", out_rdest_data, 0);
    chk("rst_store", out_store, 0);

    // back-to-back stream, 1-cycle latency
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0010 + 16'(i), 3'(i),
            32'h11111111 * i, 1'b0);
      chk("str_in_ready", in_ready, 1);
      step();
      chk("str_valid", out_valid, 1);
      chk("str_addr", out_mem_addr, 64'h10 + 64'(i));
      chk("str_rdest", out_rdest_addr, 64'(i));
      chk("str_data", out_rdest_data, 64'(32'h11111111 * i));
    end
    drive(1'b0, 16'h0, 3'd0, 32'h0, 1'b0);
    step();
    chk("str_empty", out_valid, 0);

    // back-pressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 16'h0100, 3'd1, 32'haaaa0001, 1'b0);
    step();
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_addr", out_mem_addr, 16'h0100);
    chk("bp_a_rdy", in_ready, 1);
    drive(1'b1, 16'h0200, 3'd2, 32'hbbbb0002, 1'b1);
    step();
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_hold_addr", out_mem_addr, 16'h0100);
    chk("bp_hold_store", out_store, 0);
    drive(1'b1, 16'h0badd, 3'd5, 32'h0, 1'b0);
    step();
    chk("bp_hold2_addr", out_mem_addr, 16'h0100);
    chk("bp_hold2_data", out_rdest_data, 32'haaaa0001);
    drive(1'b0, 16'h0, 3'd0, 32'h0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp_b_addr", out_mem_addr, 16'h0200);
    chk("bp_b_data", out_rdest_data, 32'hbbbb0002);
    chk("bp_b_store", out_store, 1);
    chk("bp_b_rdy", in_ready, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // flush while full, with a simultaneous input offered
    out_ready = 1'b0;
    drive(1'b1, 16'h0300, 3'd3, 32'h3, 1'b0);
    step();
    drive(1'b1, 16'h0400, 3'd4, 32'h4, 1'b0);
    step();
    chk("fl_full", in_ready, 0);
    drive(1'b1, 16'h0500, 3'd5, 32'h5, 1'b1);
    flush = 1'b1;
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_store", out_store, 0);
    flush = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 32'h0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("fl_nothing", out_valid, 0);
    step();
    chk("fl_nothing2", out_valid, 0);

    // store flag gated by out_valid
    drive(1'b1, 16'h0600, 3'd6, 32'h6, 1'b1);
    step();
    chk("st_valid", out_valid, 1);
    chk("st_store", out_store, 1);
    drive(1'b0, 16'h0, 3'd0, 32'h0, 1'b0);
    step();
    chk("st_idle_valid", out_valid, 0);
    chk("st_idle_store", out_store, 0);

`ifdef EXMEM_STALL_CNT_EN
    // saturating stall counter, immune to flush
    out_ready = 1'b0;
    drive(1'b1, 16'h0700, 3'd7, 32'h7, 1'b0);
    step();
    drive(1'b0, 16'h0, 3'd0, 32'h0, 1'b0);
    chk("sc_first", stall_cnt, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sc_sat", stall_cnt, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sc_flush", stall_cnt, 15);
    resetn = 1'b0;
    step();
    chk("sc_reset", stall_cnt, 0);
    resetn = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
